pattern_serializer: RTL

Serial pattern transmitter: accepts parallel words over a valid/ready handshake and shifts them out MSB-first on a single-bit line that idles high. It drives the serial input of the team's Moore "0-then-1" pattern detectors and produces the stimulus stream for them. It also keeps a running count of the 0→1 transitions it emits, which is the expected detector hit count.

---
 rtl/pattern_pkg.sv | 16 +
 rtl/pattern_hold_buf.sv | 28 ++
 rtl/pattern_serializer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern serializer and the 0-then-1 detectors.
package pattern_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } pat_state_t;

   // Level of the serial line whenever no word bit is being driven.
   localparam logic IDLE_LEVEL = 1'b1;

   // Width of the inter-word gap down-counter (GAP is at most 15).
   localparam int GAP_W = 4;

endpackage

// File: rtl/pattern_hold_buf.sv
// One-entry holding buffer between the upstream handshake and the shifter.
module pattern_hold_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd,
   output logic             full,
   output logic [WIDTH-1:0] data
);

   // A write only lands in an empty entry; a read only frees a full one, so
   // a coincident write/read never loses the word being read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full <= 1'b0;
         data <= '0;
      end else if (wr && !full) begin
         full <= 1'b1;
         data <= wr_data;
      end else if (rd && full) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/pattern_serializer.sv
// Parallel-in, MSB-first serial pattern transmitter with 0->1 edge counter.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | line idles high, waiting for a buffered word
//   ST_SHIFT | word bits on ser_out, bitcnt counts down to the LSB
//   ST_GAP   | line held high, gapcnt counts down the inter-word gap
module pattern_serializer
   import pattern_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int GAP   = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             clr_count,
   output logic             ser_out,
   output logic             word_done,
   output logic             busy,
   output logic [CNT_W-1:0] pattern_count
);

   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0]    BIT_LD  = BW'(WIDTH - 1);
   localparam logic [BW-1:0]    BIT_ONE = BW'(1);
   localparam logic [GAP_W-1:0] GAP_LD  = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
   localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam bit               HAS_GAP = (GAP > 0);

   pat_state_t       state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bitcnt;
   logic [GAP_W-1:0] gapcnt;
   logic             buf_full;
   logic [WIDTH-1:0] buf_data;
   logic             bitcnt_tc, gapcnt_tc;
   logic             load, shift, gap_ld, gap_dec;
   logic             ser_nxt, done_nxt;
   logic             rise;

   assign in_ready  = !buf_full;
   assign busy      = (state != ST_IDLE) || buf_full;
   assign bitcnt_tc = (bitcnt == '0);
   assign gapcnt_tc = (gapcnt == '0);
   assign rise      = !ser_out && ser_nxt;

   pattern_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
      .clk     (clk),
      .reset   (reset),
      .wr      (in_valid && in_ready),
      .wr_data (in_data),
      .rd      (load),
      .full    (buf_full),
      .data    (buf_data)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (buf_full) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (bitcnt_tc) begin
               if (HAS_GAP)       state_nxt = ST_GAP;
               else if (buf_full) state_nxt = ST_SHIFT;
               else               state_nxt = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gapcnt_tc) state_nxt = buf_full ? ST_SHIFT : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Datapath controls and next values of the registered outputs.
   always_comb begin
      load     = 1'b0;
      shift    = 1'b0;
      gap_ld   = 1'b0;
      gap_dec  = 1'b0;
      ser_nxt  = IDLE_LEVEL;
      done_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (buf_full) begin
               load    = 1'b1;
               ser_nxt = buf_data[WIDTH-1];
            end
         end
         ST_SHIFT: begin
            if (!bitcnt_tc) begin
               shift    = 1'b1;
               ser_nxt  = shreg[WIDTH-2];
               done_nxt = (bitcnt == BIT_ONE);
            end else if (HAS_GAP) begin
               gap_ld = 1'b1;
            end else if (buf_full) begin
               load    = 1'b1;
               ser_nxt = buf_data[WIDTH-1];
            end
         end
         ST_GAP: begin
            if (!gapcnt_tc) begin
               gap_dec = 1'b1;
            end else if (buf_full) begin
               load    = 1'b1;
               ser_nxt = buf_data[WIDTH-1];
            end
         end
         default: ser_nxt = IDLE_LEVEL;
      endcase
   end

   // Shift register, bit/gap down-counters and registered serial outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg     <= '0;
         bitcnt    <= '0;
         gapcnt    <= '0;
         ser_out   <= IDLE_LEVEL;
         word_done <= 1'b0;
      end else begin
         if (load) begin
            shreg  <= buf_data;
            bitcnt <= BIT_LD;
         end else if (shift) begin
            shreg  <= shreg << 1;
            bitcnt <= bitcnt - BIT_ONE;
         end
         if (gap_ld)       gapcnt <= GAP_LD;
         else if (gap_dec) gapcnt <= gapcnt - GAP_ONE;
         ser_out   <= ser_nxt;
         word_done <= done_nxt;
      end
   end

   // Saturating 0->1 transition counter; clear beats a coincident increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pattern_count <= '0;
      end else if (clr_count) begin
         pattern_count <= '0;
      end else if (rise && (pattern_count != '1)) begin
         pattern_count <= pattern_count + CNT_ONE;
      end
   end

endmodule
